// File: rtl/sobel_frame_sequencer_if.sv
// Frame-sequencer bus: start/busy/done handshake, pixel RAM read port,
// innerSobel window/result and bitmap RAM write port.
interface sobel_frame_sequencer_if #(
  parameter int unsigned ADDR_W = 14
);
  logic              start;
  logic [7:0]        threshold;
  logic              busy;
  logic              done;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [7:0]        mem_rd_data;
  logic [7:0]        p0, p1, p2, p3, p5, p6, p7, p8;
  logic [7:0]        sum;
  logic              out_we;
  logic [ADDR_W-1:0] out_addr;
  logic              out_bit;

  modport master (
    input  start, threshold, mem_rd_data, sum,
    output busy, done, mem_rd_en, mem_rd_addr,
           p0, p1, p2, p3, p5, p6, p7, p8,
           out_we, out_addr, out_bit
  );

  modport slave (
    output start, threshold, mem_rd_data, sum,
    input  busy, done, mem_rd_en, mem_rd_addr,
           p0, p1, p2, p3, p5, p6, p7, p8,
           out_we, out_addr, out_bit
  );
endinterface

// File: rtl/sobel_frame_sequencer.sv
// Sequences innerSobel over a WIDTH x DEPTH frame: clears the bitmap, then
// streams pixels through two line buffers and a 3x3 window, writing edge bits.
module sobel_frame_sequencer #(
  parameter int unsigned WIDTH  = 128,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned ADDR_W = 14
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sobel_frame_sequencer_if.master bus
);

  localparam int unsigned NPIX = WIDTH * DEPTH;
  localparam int unsigned CW   = $clog2(WIDTH);
  localparam int unsigned RW   = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NPIX - 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SCAN, S_DRAIN, S_DONE} state_t;

  state_t            state;
  logic [7:0]        thr_q;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [1:0]        drain_cnt;

  // Stage 1: read data arriving; stage 2: window registered, sum valid.
  logic              v1, v2;
  logic [CW-1:0]     c1, c2;
  logic [RW-1:0]     r1, r2;
  logic [ADDR_W-1:0] a1, a2;
  logic [7:0]        ctr;

  logic [7:0] lb_a [WIDTH];
  logic [7:0] lb_b [WIDTH];

  always_ff @(posedge clk) begin
    if (v1) begin
      lb_a[c1] <= lb_b[c1];
      lb_b[c1] <= bus.mem_rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      thr_q         <= '0;
      col           <= '0;
      row           <= '0;
      drain_cnt     <= '0;
      v1            <= 1'b0;
      v2            <= 1'b0;
      c1            <= '0;
      c2            <= '0;
      r1            <= '0;
      r2            <= '0;
      a1            <= '0;
      a2            <= '0;
      ctr           <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.mem_rd_en <= 1'b0;
      bus.mem_rd_addr <= '0;
      bus.p0 <= '0; bus.p1 <= '0; bus.p2 <= '0; bus.p3 <= '0;
      bus.p5 <= '0; bus.p6 <= '0; bus.p7 <= '0; bus.p8 <= '0;
      bus.out_we    <= 1'b0;
      bus.out_addr  <= '0;
      bus.out_bit   <= 1'b0;
    end else begin
      bus.done <= 1'b0;

      v1 <= bus.mem_rd_en;
      c1 <= col;
      r1 <= row;
      a1 <= bus.mem_rd_addr;
      v2 <= v1;
      c2 <= c1;
      r2 <= r1;
      a2 <= a1;

      if (v1) begin
        bus.p0 <= bus.p1; bus.p1 <= bus.p2; bus.p2 <= lb_a[c1];
        bus.p3 <= ctr;    ctr    <= bus.p5; bus.p5 <= lb_b[c1];
        bus.p6 <= bus.p7; bus.p7 <= bus.p8; bus.p8 <= bus.mem_rd_data;
      end

      // Newest column c2 >= 2 and row r2 >= 2 means the window centre is interior.
      bus.out_we <= v2 && (c2 >= CW'(2)) && (r2 >= RW'(2));
      if (v2 && (c2 >= CW'(2)) && (r2 >= RW'(2))) begin
        bus.out_addr <= a2 - ADDR_W'(WIDTH + 1);
        bus.out_bit  <= (bus.sum > thr_q);
      end

      case (state)
        S_IDLE: begin
          if (bus.start) begin
            thr_q        <= bus.threshold;
            state        <= S_CLEAR;
            bus.busy     <= 1'b1;
            bus.out_we   <= 1'b1;
            bus.out_addr <= '0;
            bus.out_bit  <= 1'b0;
          end
        end
        S_CLEAR: begin
          if (bus.out_addr == LAST) begin
            state           <= S_SCAN;
            bus.out_we      <= 1'b0;
            bus.mem_rd_en   <= 1'b1;
            bus.mem_rd_addr <= '0;
            col             <= '0;
            row             <= '0;
          end else begin
            bus.out_we   <= 1'b1;
            bus.out_addr <= bus.out_addr + 1'b1;
          end
        end
        S_SCAN: begin
          if (bus.mem_rd_addr == LAST) begin
            state           <= S_DRAIN;
            bus.mem_rd_en   <= 1'b0;
            bus.mem_rd_addr <= '0;
            col             <= '0;
            row             <= '0;
            drain_cnt       <= '0;
          end else begin
            bus.mem_rd_addr <= bus.mem_rd_addr + 1'b1;
            if (col == CW'(WIDTH - 1)) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          if (drain_cnt == 2'd2) begin
            state    <= S_DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
